sqrt_iter: RTL
==============

Name: sqrt_iter

Overview:
- Iteration stage of the FP16 square-root pipeline. Sits directly upstream of the pack stage.
- Accepts one unpacked operand: sign, unbiased exponent, 11-bit mantissa with hidden bit, plus special flags.
- Computes the root mantissa with a restoring bit-per-cycle algorithm and halves the exponent.
- Presents the result to pack as a one-cycle it_valid pulse.

Parameters:
- MANT_W, 11, mantissa width including hidden bit; also the root width.
- EXP_W, 7, signed unbiased exponent width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  low: behaves as soft clear, same effect as rst.
- in_valid  in  1  operand present.
- in_ready  out  1  high only in IDLE.
- sign_in  in  1  operand sign.
- exp_in  in  7  signed unbiased exponent.
- mant_in  in  11  normalized mantissa; bit10=1 unless is_zero_in.
- is_zero_in  in  1  operand is ±0.
- is_nan_in  in  1  operand is NaN.
- is_pinf_in  in  1  operand is +inf.
- is_ninf_in  in  1  operand is -inf.
- it_valid  out  1  one-cycle result strobe to pack.
- sign_out  out  1  result sign.
- exp_out  out  7  signed unbiased result exponent.
- mant_out  out  11  root mantissa, Q1.10.
- is_nan_out  out  1  result is NaN.
- is_pinf_out  out  1  result is +inf.
- is_ninf_out  out  1  result is -inf; always 0 for sqrt.
- result_out  out  1  inexact flag: final remainder nonzero.

Behaviour:
- Reset (rst=1 or enable=0 at an edge): state=IDLE. All outputs cleared to 0 except in_ready=1.
- Reset takes priority over every other event. It aborts CALC/DONE silently with no it_valid and no partial result.
- State machine IDLE -> CALC -> DONE -> IDLE.
- IDLE: in_valid=1 accepts the operand at that edge. Inputs are sampled only at the accepting edge.
- Special operands go IDLE -> DONE directly: it_valid pulses 1 edge after acceptance.
  - NaN, -inf, or sign=1 with nonzero operand -> is_nan_out=1, sign_out=1.
  - +inf -> is_pinf_out=1.
  - ±0 -> sign_out=sign_in, exp_out=-15, mant_out=0, result_out=0. Pack renders this as signed zero.
- Normal operand:
  - odd = exp_in[0].
  - exp_out = exp_in >>> 1 (arithmetic shift, floor). Example: -3 -> -2.
  - Radicand X = mant_in << (10+odd), 22 bits.
  - CALC runs N iterations, N=11. Each iteration brings down 2 radicand bits and performs a trial subtract of (root<<2|1) from the remainder. On no borrow, root bit=1 and the remainder is updated; otherwise root bit=0.
  - Iteration counter counts 0..N-1; leave CALC when counter=N-1.
  - mant_out = root[10:0], always with bit10=1. result_out = (remainder != 0). sign_out=0.
- DONE: it_valid=1 for exactly one cycle. The output registers hold their values until the next DONE or reset, then return to IDLE.
- Normal latency: it_valid high after the (N+1)th rising edge following the accepting edge. Throughput: one operand per N+2 cycles.
- in_valid while busy is ignored; the upstream stage holds its data until in_ready.
- Flags are mutually exclusive at the input. If more than one is set, priority is nan > ninf > pinf > zero.
- Back-to-back: acceptance is possible on the edge that leaves DONE? No — acceptance is only from IDLE, so there is at least one idle cycle between results.

Optional Feature:
- Macro SQRT_ROUND_EN.
- Defined:
  - N=12; one guard root bit is computed.
  - mant_out = root[11:1] + root[0] (round half up).
  - Carry to 0x800 produces mant_out=0x400 and exp_out+1.
  - result_out = guard bit or nonzero remainder.
  - Normal latency 13 edges.
- Undefined: truncation, N=11, latency 12 edges.

Test Plan:
- sqrt(4.0): exp_in=2, mant_in=0x400 -> exp_out=1, mant_out=0x400, result_out=0. it_valid exactly 12 edges after accept, 1 cycle wide.
- sqrt(2.0): exp_in=1, mant_in=0x400 -> exp_out=0, mant_out=0x5A8, result_out=1. Same value with SQRT_ROUND_EN, latency 13.
- Negative odd exponent: exp_in=-3, mant_in=0x400 -> exp_out=-2, mant_out=0x5A8. Check sqrt(2.25): exp_in=1, mant_in=0x480 -> mant_out=0x600, result_out=0.
- Specials:
  - sqrt(-1) -> is_nan_out=1.
  - +inf -> is_pinf_out=1.
  - -0 -> sign_out=1, mant_out=0, exp_out=-15.
  - Each gives it_valid 1 edge after accept.
- rst pulse 5 cycles into CALC -> no it_valid, outputs 0, in_ready=1 next cycle. The next operand (4.0) yields a correct result. Repeat using enable=0 instead of rst.
- in_valid held high continuously with changing data -> only operands sampled in IDLE are processed. Verify one it_valid per accepted operand and correct values.

Source files
------------

// File: rtl/sqrt_iter_if.sv
// sqrt_iter_if: operand/result bundle between the unpack stage, the square-root
// iteration stage and the pack stage.
//   Operand side : in_valid, in_ready, sign_in, exp_in, mant_in, is_*_in flags
//   Result side  : it_valid, sign_out, exp_out, mant_out, is_*_out flags, result_out
// The slave modport is the iteration stage's view of the bundle; the master
// modport is the surrounding environment's view (drives operands, observes results).
interface sqrt_iter_if #(
  parameter int MANT_W = 11,
  parameter int EXP_W  = 7
);
  logic                    in_valid;
  logic                    in_ready;
  logic                    sign_in;
  logic signed [EXP_W-1:0] exp_in;
  logic [MANT_W-1:0]       mant_in;
  logic                    is_zero_in;
  logic                    is_nan_in;
  logic                    is_pinf_in;
  logic                    is_ninf_in;

  logic                    it_valid;
  logic                    sign_out;
  logic signed [EXP_W-1:0] exp_out;
  logic [MANT_W-1:0]       mant_out;
  logic                    is_nan_out;
  logic                    is_pinf_out;
  logic                    is_ninf_out;
  logic                    result_out;

  modport slave (
    input  in_valid, sign_in, exp_in, mant_in,
           is_zero_in, is_nan_in, is_pinf_in, is_ninf_in,
    output in_ready, it_valid, sign_out, exp_out, mant_out,
           is_nan_out, is_pinf_out, is_ninf_out, result_out
  );

  modport master (
    output in_valid, sign_in, exp_in, mant_in,
           is_zero_in, is_nan_in, is_pinf_in, is_ninf_in,
    input  in_ready, it_valid, sign_out, exp_out, mant_out,
           is_nan_out, is_pinf_out, is_ninf_out, result_out
  );
endinterface

// File: rtl/sqrt_iter.sv
// sqrt_iter: iteration stage of the FP16 square-root pipeline.
// Takes one unpacked operand, computes the root mantissa with a restoring
// bit-per-cycle algorithm, halves the exponent and hands the result to the
// pack stage as a one-cycle it_valid strobe.
// Ports:
//   clk    - rising-edge clock
//   rst    - synchronous active-high reset
//   enable - low acts as a soft clear (same effect as rst)
//   bus    - sqrt_iter_if.slave: operand handshake/fields in, result fields out
// Optional build macro SQRT_ROUND_EN: computes one extra guard root bit and
// rounds half up (12 iterations); undefined gives truncation (11 iterations).
module sqrt_iter #(
  parameter int MANT_W = 11,
  parameter int EXP_W  = 7
) (
  input logic         clk,
  input logic         rst,
  input logic         enable,
  sqrt_iter_if.slave  bus
);

`ifdef SQRT_ROUND_EN
  localparam int N = MANT_W + 1;
`else
  localparam int N = MANT_W;
`endif
  localparam int XW  = 2 * N;          // radicand width
  localparam int RW  = N + 3;          // remainder width incl. the 2 brought-down bits
  localparam int CW  = $clog2(N);
  localparam int XSH = XW - MANT_W - 1; // aligns the Q1.10 mantissa to a Q1.(N-1) root

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;
  typedef enum logic [1:0] {K_NORM, K_NAN, K_PINF, K_ZERO} kind_t;

  state_t                  r_state, w_next;
  kind_t                   r_kind, w_kind;
  logic                    w_clr, w_accept;
  logic                    r_sign;
  logic signed [EXP_W-1:0] r_exp;
  logic [XW-1:0]           r_x, w_x_init;
  logic [RW-1:0]           r_rem, w_rem_sh, w_trial, w_diff;
  logic                    w_ge;
  logic [N-1:0]            r_root;
  logic [CW-1:0]           r_cnt;

  logic [MANT_W:0]         w_rnd;
  logic                    w_inexact;
  logic                    w_res_sign, w_res_nan, w_res_pinf, w_res_inex;
  logic signed [EXP_W-1:0] w_res_exp;
  logic [MANT_W-1:0]       w_res_mant;

  logic                    r_it_valid, r_sign_o, r_nan_o, r_pinf_o, r_inex_o;
  logic signed [EXP_W-1:0] r_exp_o;
  logic [MANT_W-1:0]       r_mant_o;

  function automatic logic [MANT_W:0] round_root(input logic [N-1:0] root);
`ifdef SQRT_ROUND_EN
    return {1'b0, root[N-1:1]} + {{MANT_W{1'b0}}, root[0]};
`else
    return {1'b0, root};
`endif
  endfunction

  assign w_clr    = rst | ~enable;
  assign w_accept = (r_state == S_IDLE) & bus.in_valid;

  // Operand classification; flag priority nan > ninf > pinf > zero, then
  // any remaining negative operand has no real root.
  always_comb begin
    w_kind = K_NORM;
    if (bus.is_nan_in || bus.is_ninf_in) w_kind = K_NAN;
    else if (bus.is_pinf_in)             w_kind = K_PINF;
    else if (bus.is_zero_in)             w_kind = K_ZERO;
    else if (bus.sign_in)                w_kind = K_NAN;
  end

  // An odd exponent is folded into the radicand by one extra left shift.
  assign w_x_init = {{(XW-MANT_W){1'b0}}, bus.mant_in} << (XSH + int'(bus.exp_in[0]));

  // ---- iteration: bring down 2 radicand bits, trial-subtract (root<<2 | 1)
  assign w_rem_sh = {r_rem[RW-3:0], r_x[XW-1 -: 2]};
  assign w_trial  = {1'b0, r_root, 2'b01};
  assign w_ge     = (w_rem_sh >= w_trial);
  assign w_diff   = w_rem_sh - w_trial;

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (bus.in_valid) w_next = (w_kind == K_NORM) ? S_CALC : S_DONE;
      S_CALC:  if (r_cnt == CW'(N-1)) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_clr) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_kind <= w_kind;
      r_sign <= bus.sign_in;
      r_exp  <= bus.exp_in >>> 1;
      r_x    <= w_x_init;
      r_rem  <= '0;
      r_root <= '0;
    end else if (r_state == S_CALC) begin
      r_x    <= r_x << 2;
      r_rem  <= w_ge ? w_diff : w_rem_sh;
      r_root <= {r_root[N-2:0], w_ge};
    end
  end

  // ---- result formation (evaluated in DONE)
`ifdef SQRT_ROUND_EN
  assign w_inexact = r_root[0] | (|r_rem);
`else
  assign w_inexact = |r_rem;
`endif

  always_comb begin
    w_rnd      = round_root(r_root);
    w_res_sign = 1'b0;
    w_res_exp  = '0;
    w_res_mant = '0;
    w_res_nan  = 1'b0;
    w_res_pinf = 1'b0;
    w_res_inex = 1'b0;
    unique case (r_kind)
      K_NAN: begin
        w_res_nan  = 1'b1;
        w_res_sign = 1'b1;
      end
      K_PINF: w_res_pinf = 1'b1;
      K_ZERO: begin
        w_res_sign = r_sign;
        w_res_exp  = EXP_W'(-15);
      end
      default: begin
        // A rounding carry out of the mantissa renormalises to 1.0 and bumps the exponent.
        if (w_rnd[MANT_W]) begin
          w_res_mant = MANT_W'(1) << (MANT_W-1);
          w_res_exp  = r_exp + EXP_W'(1);
        end else begin
          w_res_mant = w_rnd[MANT_W-1:0];
          w_res_exp  = r_exp;
        end
        w_res_inex = w_inexact;
      end
    endcase
  end

  // ---- output registers: loaded once per result, held until the next one
  always_ff @(posedge clk) begin
    if (w_clr) begin
      r_cnt      <= '0;
      r_it_valid <= 1'b0;
      r_sign_o   <= 1'b0;
      r_exp_o    <= '0;
      r_mant_o   <= '0;
      r_nan_o    <= 1'b0;
      r_pinf_o   <= 1'b0;
      r_inex_o   <= 1'b0;
    end else begin
      if (w_accept)                r_cnt <= '0;
      else if (r_state == S_CALC)  r_cnt <= r_cnt + CW'(1);
      r_it_valid <= (r_state == S_DONE);
      if (r_state == S_DONE) begin
        r_sign_o <= w_res_sign;
        r_exp_o  <= w_res_exp;
        r_mant_o <= w_res_mant;
        r_nan_o  <= w_res_nan;
        r_pinf_o <= w_res_pinf;
        r_inex_o <= w_res_inex;
      end
    end
  end

  assign bus.in_ready    = (r_state == S_IDLE);
  assign bus.it_valid    = r_it_valid;
  assign bus.sign_out    = r_sign_o;
  assign bus.exp_out     = r_exp_o;
  assign bus.mant_out    = r_mant_o;
  assign bus.is_nan_out  = r_nan_o;
  assign bus.is_pinf_out = r_pinf_o;
  assign bus.is_ninf_out = 1'b0;
  assign bus.result_out  = r_inex_o;

endmodule
